prbs_gen_multi: RTL and testbench
=================================

# prbs_gen_multi

Parametrised multi-polynomial PRBS source for the BER tester transmit path. It emits DATA_W pseudo-random bits per accepted word, selectable among PRBS7/15/23/31, on a valid/ready stream. It adds runtime seed load, per-byte lane masking and optional single-bit error injection. It feeds the serializer/TX datapath; the checker on the receive side uses the same polynomial set.

## Interface
- DATA_W, 32: output word width in bits; multiple of 8, range 8..64.
- SEED, 31'b1101111011110110011100011101101: reset seed; the low N bits are used for an N-bit polynomial.

- clk_in  in  1  single clock; all logic rising-edge.
- rst_in  in  1  reset, synchronous, active-high.
- mode_in  in  2  polynomial: 0 = PRBS7 (x^7+x^6+1), 1 = PRBS15 (x^15+x^14+1), 2 = PRBS23 (x^23+x^18+1), 3 = PRBS31 (x^31+x^28+1).
- seed_load_in  in  1  one-cycle pulse: reload the LFSR from seed_in and latch mode_in.
- seed_in  in  31  runtime seed; low N bits used.
- byte_ctrl_in  in  DATA_W/8  lane enable; a disabled byte lane outputs 0x00.
- err_inj_in  in  1  request a one-bit error (only with PRBS_GEN_ERR_INJ_EN).
- data_ready_in  in  1  downstream accepts data_out.
- data_valid_out  out  1  data_out holds a valid word.
- data_out  out  DATA_W  PRBS word; data_out[DATA_W-1] is the earliest bit in the serial stream.

## Operation
- LFSR is Fibonacci form, N = 7/15/23/31 by latched mode.
  - Serial bit = s[N-1].
  - Shift left; new s[0] = s[N-1] ^ s[T-1], with T = 6/14/18/28.
- A word is DATA_W consecutive serial bits, MSB first. The LFSR advances exactly DATA_W steps per word loaded into the output register.
- Output register load condition: `!data_valid_out || data_ready_in`. Otherwise data_out is held (backpressure). No words are lost or duplicated.
- Lane masking:
  - Applied at output-register load, using byte_ctrl_in sampled that cycle.
  - The LFSR advances the full DATA_W regardless of the mask.
- Mode is latched only at reset (from mode_in) and on seed_load_in. Changes to mode_in at other times are ignored.
- Zero-state guard: if the masked seed is all-zero, load 1 (s[0]=1).
- seed_load_in:
  - Has priority over the handshake.
  - That edge: LFSR <= seed, mode latched, data_valid_out <= 0.
  - The next edge loads the first word from the new seed.

## Timing
- Reset values: data_valid_out = 0, data_out = 0, LFSR = SEED (guarded), mode = mode_in.
- First edge with rst_in = 0: word 0 loaded, data_valid_out = 1.
- Throughput: one word per cycle while data_ready_in = 1.
- Latency seed_load_in -> first new valid word: 2 edges.
- Reset asserted mid-stream: takes effect at the next edge and overrides everything, including seed_load_in and a pending error injection.
- Simultaneous seed_load_in and err_inj_in: the injection applies to the first word from the new seed.

## Configuration
- PRBS_GEN_ERR_INJ_EN defined:
  - A pulse on err_inj_in sets a pending flag.
  - The next word loaded into the output register has data_out[0] inverted, then the flag clears.
  - The LFSR state is never corrupted.
  - Pulses while the flag is already pending merge into one error.
- Not defined: err_inj_in is ignored, no flag logic is present, and the stream is pure PRBS.

## Structure
- Package prbs_pkg:
  - mode encodings PRBS7..PRBS31.
  - per-mode length N and tap T constants.
  - LFSR_MAX_W = 31.
- Sub-module prbs_lfsr_step:
  - Combinational.
  - Given state, mode and DATA_W, returns the DATA_W output bits and the next state for all four polynomials, muxed by mode.
- Top level: mode/seed latch, output register with handshake, lane mask, error-injection flag.

## Test plan
- PRBS7, DATA_W=8, SEED low bits 7'h7F, ready=1 -> words 8'hFE, 8'h04, …; word 127 equals word 0 (8'hFE).
- PRBS31, DATA_W=32, ready=1 -> 2^31-1 step period checked against a bit-serial golden model for 10k words, zero mismatches.
- Backpressure: deassert ready for 5 cycles mid-stream -> data_out stable, valid held; resumed sequence is contiguous with the golden model.
- DATA_W=32, byte_ctrl_in=4'b0101 -> bytes [15:8] and [31:24] = 0x00, others match the golden model; after restoring 4'b1111 the stream stays in sequence.
- seed_load_in with seed_in=0 in PRBS15 -> valid low for 1 cycle, then a stream equal to the golden model from state 15'h0001.
- With PRBS_GEN_ERR_INJ_EN: err_inj_in pulse -> exactly one following word differs from the golden model, only in bit 0; without the macro, no difference.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg
//   Shared definitions for the multi-polynomial PRBS generator: mode encodings,
//   per-mode LFSR length (N) and feedback tap (T), and small helpers that turn
//   a mode into bit indices, a state mask and a zero-guarded seed.
//   Ports: none (package).
//   Configuration: PRBS_GEN_ERR_INJ_EN is consumed by prbs_gen_multi only.
package prbs_pkg;

   localparam int unsigned LFSR_MAX_W = 31;

   typedef enum logic [1:0] {
      PRBS7  = 2'd0,
      PRBS15 = 2'd1,
      PRBS23 = 2'd2,
      PRBS31 = 2'd3
   } prbs_mode_e;

   localparam int unsigned PRBS7_N  = 7;
   localparam int unsigned PRBS7_T  = 6;
   localparam int unsigned PRBS15_N = 15;
   localparam int unsigned PRBS15_T = 14;
   localparam int unsigned PRBS23_N = 23;
   localparam int unsigned PRBS23_T = 18;
   localparam int unsigned PRBS31_N = 31;
   localparam int unsigned PRBS31_T = 28;

   // Index of s[N-1], the serial output bit.
   function automatic logic [4:0] mode_msb(input logic [1:0] mode);
      case (mode)
         PRBS7:   return 5'(PRBS7_N - 1);
         PRBS15:  return 5'(PRBS15_N - 1);
         PRBS23:  return 5'(PRBS23_N - 1);
         default: return 5'(PRBS31_N - 1);
      endcase
   endfunction

   // Index of s[T-1], the second feedback tap.
   function automatic logic [4:0] mode_tap(input logic [1:0] mode);
      case (mode)
         PRBS7:   return 5'(PRBS7_T - 1);
         PRBS15:  return 5'(PRBS15_T - 1);
         PRBS23:  return 5'(PRBS23_T - 1);
         default: return 5'(PRBS31_T - 1);
      endcase
   endfunction

   function automatic logic [LFSR_MAX_W-1:0] mode_mask(input logic [1:0] mode);
      case (mode)
         PRBS7:   return 31'h0000_007F;
         PRBS15:  return 31'h0000_7FFF;
         PRBS23:  return 31'h007F_FFFF;
         default: return 31'h7FFF_FFFF;
      endcase
   endfunction

   // An all-zero LFSR would lock up; force s[0]=1 in that case.
   function automatic logic [LFSR_MAX_W-1:0] seed_guard(input logic [LFSR_MAX_W-1:0] seed,
                                                        input logic [1:0]            mode);
      logic [LFSR_MAX_W-1:0] masked;
      masked = seed & mode_mask(mode);
      if (masked == '0) begin
         masked = {{(LFSR_MAX_W-1){1'b0}}, 1'b1};
      end
      return masked;
   endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// prbs_lfsr_step
//   Combinational word step of the Fibonacci LFSR. Runs DATA_W serial steps
//   for each of the four polynomials and selects the result by mode.
//   Ports:
//     state      in   LFSR_MAX_W  current LFSR state (unused high bits are 0)
//     mode       in   2           polynomial select (prbs_mode_e encoding)
//     bits       out  DATA_W      serial bits, earliest bit in bits[DATA_W-1]
//     next_state out  LFSR_MAX_W  state after DATA_W steps
module prbs_lfsr_step import prbs_pkg::*; #(
   parameter int unsigned DATA_W = 32
) (
   input  logic [LFSR_MAX_W-1:0] state,
   input  logic [1:0]            mode,
   output logic [DATA_W-1:0]     bits,
   output logic [LFSR_MAX_W-1:0] next_state
);

   // Returns {bits, next_state} for one polynomial.
   function automatic logic [DATA_W+LFSR_MAX_W-1:0] run_poly(input logic [LFSR_MAX_W-1:0] seed,
                                                            input logic [1:0]            sel);
      logic [LFSR_MAX_W-1:0] s;
      logic [DATA_W-1:0]     b;
      logic [4:0]            msb;
      logic [4:0]            tap;
      s   = seed;
      b   = '0;
      msb = mode_msb(sel);
      tap = mode_tap(sel);
      for (int i = 0; i < DATA_W; i++) begin
         b = {b[DATA_W-2:0], s[msb]};
         // Mask keeps the shifted-out MSB from leaking above bit N-1.
         s = {s[LFSR_MAX_W-2:0], s[msb] ^ s[tap]} & mode_mask(sel);
      end
      return {b, s};
   endfunction

   logic [DATA_W+LFSR_MAX_W-1:0] res7;
   logic [DATA_W+LFSR_MAX_W-1:0] res15;
   logic [DATA_W+LFSR_MAX_W-1:0] res23;
   logic [DATA_W+LFSR_MAX_W-1:0] res31;

   assign res7  = run_poly(state, PRBS7);
   assign res15 = run_poly(state, PRBS15);
   assign res23 = run_poly(state, PRBS23);
   assign res31 = run_poly(state, PRBS31);

   always_comb begin
      case (mode)
         PRBS7:   {bits, next_state} = res7;
         PRBS15:  {bits, next_state} = res15;
         PRBS23:  {bits, next_state} = res23;
         default: {bits, next_state} = res31;
      endcase
   end

endmodule

// File: rtl/prbs_gen_multi.sv
// prbs_gen_multi
//   Multi-polynomial PRBS source (PRBS7/15/23/31) on a valid/ready stream with
//   runtime seed load, per-byte lane masking and optional single-bit error
//   injection. The LFSR advances DATA_W steps per word loaded into the output
//   register; data_out[DATA_W-1] is the earliest serial bit.
//   Ports:
//     clk_in          in   1         clock, rising edge
//     rst_in          in   1         synchronous active-high reset
//     mode_in         in   2         polynomial, latched at reset / seed load
//     seed_load_in    in   1         reload LFSR from seed_in, latch mode_in
//     seed_in         in   31        runtime seed, low N bits used
//     byte_ctrl_in    in   DATA_W/8  lane enable, disabled lane outputs 0x00
//     err_inj_in      in   1         request a one-bit error
//     data_ready_in   in   1         downstream accepts data_out
//     data_valid_out  out  1         data_out holds a valid word
//     data_out        out  DATA_W    PRBS word
//   Configuration: define PRBS_GEN_ERR_INJ_EN to enable error injection;
//   otherwise err_inj_in is ignored.
module prbs_gen_multi import prbs_pkg::*; #(
   parameter int unsigned         DATA_W = 32,
   parameter logic [LFSR_MAX_W-1:0] SEED = 31'b1101111011110110011100011101101
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [1:0]            mode_in,
   input  logic                  seed_load_in,
   input  logic [LFSR_MAX_W-1:0] seed_in,
   input  logic [DATA_W/8-1:0]   byte_ctrl_in,
   input  logic                  err_inj_in,
   input  logic                  data_ready_in,
   output logic                  data_valid_out,
   output logic [DATA_W-1:0]     data_out
);

   logic [1:0]            mode;
   logic [LFSR_MAX_W-1:0] lfsr;
   logic [DATA_W-1:0]     step_bits;
   logic [LFSR_MAX_W-1:0] step_next;
   logic [DATA_W-1:0]     lane_mask;
   logic [DATA_W-1:0]     word;
   logic                  load;

   assign load = !data_valid_out || data_ready_in;

   prbs_lfsr_step #(
      .DATA_W (DATA_W)
   ) u_step (
      .state      (lfsr),
      .mode       (mode),
      .bits       (step_bits),
      .next_state (step_next)
   );

   always_comb begin
      lane_mask = '0;
      for (int b = 0; b < DATA_W / 8; b++) begin
         lane_mask[8*b +: 8] = {8{byte_ctrl_in[b]}};
      end
   end

`ifdef PRBS_GEN_ERR_INJ_EN
   logic err_pend;

   // Pending flag is consumed by the next word load; pulses that arrive while
   // it is pending (including on the consuming edge) merge into that error.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         err_pend <= 1'b0;
      end else if (load && !seed_load_in) begin
         err_pend <= err_pend ? 1'b0 : err_inj_in;
      end else begin
         err_pend <= err_pend | err_inj_in;
      end
   end

   // Error is applied before masking so a disabled lane stays 0x00.
   assign word = step_bits ^ {{(DATA_W-1){1'b0}}, err_pend};
`else
   logic unused_err_inj;
   assign unused_err_inj = err_inj_in;
   assign word           = step_bits;
`endif

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         mode           <= mode_in;
         lfsr           <= seed_guard(SEED, mode_in);
         data_valid_out <= 1'b0;
         data_out       <= '0;
      end else if (seed_load_in) begin
         mode           <= mode_in;
         lfsr           <= seed_guard(seed_in, mode_in);
         data_valid_out <= 1'b0;
      end else if (load) begin
         lfsr           <= step_next;
         data_out       <= word & lane_mask;
         data_valid_out <= 1'b1;
      end
   end

endmodule

// File: tb/tb_prbs_gen_multi.sv
// tb_prbs_gen_multi
//   Self-checking bench: an 8-bit PRBS7 instance and a 32-bit PRBS31 instance.
//   Expected words come from a bit-serial LFSR model and hand-computed values.
module tb_prbs_gen_multi;

   localparam logic [30:0] SEED32 = 31'b1101111011110110011100011101101;
`ifdef PRBS_GEN_ERR_INJ_EN
   localparam logic INJ = 1'b1;
`else
   localparam logic INJ = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  mode8, mode32;
   logic        sl8, sl32;
   logic [30:0] seed8, seed32;
   logic [0:0]  bc8;
   logic [3:0]  bc32;
   logic        ei8, ei32, rdy8, rdy32, v8, v32;
   logic [7:0]  d8;
   logic [31:0] d32;

   int n_cmp = 0;
   int n_err = 0;

   logic [30:0] gs8, gs32;
   logic [1:0]  gm8, gm32;
   logic [63:0] w;
   logic [31:0] hold, first32;

   prbs_gen_multi #(.DATA_W(8), .SEED(31'h0000007F)) u_dut8 (
      .clk_in(clk), .rst_in(rst), .mode_in(mode8), .seed_load_in(sl8), .seed_in(seed8),
      .byte_ctrl_in(bc8), .err_inj_in(ei8), .data_ready_in(rdy8),
      .data_valid_out(v8), .data_out(d8)
   );

   prbs_gen_multi #(.DATA_W(32), .SEED(SEED32)) u_dut32 (
      .clk_in(clk), .rst_in(rst), .mode_in(mode32), .seed_load_in(sl32), .seed_in(seed32),
      .byte_ctrl_in(bc32), .err_inj_in(ei32), .data_ready_in(rdy32),
      .data_valid_out(v32), .data_out(d32)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int poly_n(input logic [1:0] m);
      case (m)
         2'd0:    return 7;
         2'd1:    return 15;
         2'd2:    return 23;
         default: return 31;
      endcase
   endfunction

   function automatic int poly_t(input logic [1:0] m);
      case (m)
         2'd0:    return 6;
         2'd1:    return 14;
         2'd2:    return 18;
         default: return 28;
      endcase
   endfunction

   function automatic logic [30:0] guard(input logic [30:0] s, input logic [1:0] m);
      logic [30:0] r;
      r = s & ((31'h1 << poly_n(m)) - 31'h1);
      if (r == 31'h0) r = 31'h1;
      return r;
   endfunction

   // Bit-serial reference: w steps, earliest bit ends up in word[w-1].
   task automatic gold_word(inout logic [30:0] s, input logic [1:0] m, input int wd,
                            output logic [63:0] word);
      int n, t;
      logic fb;
      n    = poly_n(m);
      t    = poly_t(m);
      word = '0;
      for (int i = 0; i < wd; i++) begin
         word = {word[62:0], s[n-1]};
         fb   = s[n-1] ^ s[t-1];
         s    = {s[29:0], fb} & ((31'h1 << n) - 31'h1);
      end
   endtask

   initial begin
      rst = 1'b1;
      mode8 = 2'd0; sl8 = 1'b0; seed8 = '0; bc8 = 1'b1; ei8 = 1'b0; rdy8 = 1'b1;
      mode32 = 2'd3; sl32 = 1'b0; seed32 = '0; bc32 = 4'hF; ei32 = 1'b0; rdy32 = 1'b1;
      first32 = '0;
      hold    = '0;
      step();
      step();
      check_eq("rst_valid8", v8, 0);
      check_eq("rst_data8", d8, 0);
      check_eq("rst_valid32", v32, 0);
      check_eq("rst_data32", d32, 0);

      gs8 = guard(31'h7F, 2'd0);  gm8 = 2'd0;
      gs32 = guard(SEED32, 2'd3); gm32 = 2'd3;
      rst = 1'b0;
      // Mode changes outside reset/seed load must be ignored.
      mode8  = 2'd3;
      mode32 = 2'd0;

      // PRBS7 full period on the 8-bit instance, PRBS31 on the 32-bit one.
      for (int k = 0; k < 128; k++) begin
         step();
         gold_word(gs8, gm8, 8, w);
         check_eq("prbs7_word", d8, w[7:0]);
         if (k == 0) begin
            check_eq("prbs7_first_valid", v8, 1);
            check_eq("prbs7_word0", d8, 8'hFE);
         end
         if (k == 1) check_eq("prbs7_word1", d8, 8'h04);
         if (k == 127) check_eq("prbs7_wrap", d8, 8'hFE);
         gold_word(gs32, gm32, 32, w);
         check_eq("prbs31_word", d32, w[31:0]);
         if (k == 0) begin
            first32 = w[31:0];
            check_eq("prbs31_first_valid", v32, 1);
         end
      end

      for (int k = 128; k < 10000; k++) begin
         step();
         gold_word(gs32, gm32, 32, w);
         check_eq("prbs31_long", d32, w[31:0]);
         hold = w[31:0];
      end

      // Backpressure: output held, then the stream resumes contiguously.
      rdy32 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         check_eq("bp_hold_data", d32, hold);
         check_eq("bp_hold_valid", v32, 1);
      end
      rdy32 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         gold_word(gs32, gm32, 32, w);
         check_eq("bp_resume", d32, w[31:0]);
      end

      // Lane mask: bytes 1 and 3 disabled; LFSR still advances full width.
      bc32 = 4'b0101;
      for (int k = 0; k < 3; k++) begin
         step();
         gold_word(gs32, gm32, 32, w);
         check_eq("mask_0101", d32, w[31:0] & 32'h00FF00FF);
      end
      bc32 = 4'hF;
      for (int k = 0; k < 3; k++) begin
         step();
         gold_word(gs32, gm32, 32, w);
         check_eq("mask_restored", d32, w[31:0]);
      end

      // Seed load with zero seed in PRBS15: guarded to 15'h0001.
      seed32 = '0;
      mode32 = 2'd1;
      sl32   = 1'b1;
      step();
      check_eq("seed_valid_low", v32, 0);
      sl32   = 1'b0;
      mode32 = 2'd3;
      gs32   = 31'h1;
      gm32   = 2'd1;
      step();
      check_eq("seed_valid_high", v32, 1);
      check_eq("seed_word0_hand", d32, 32'h0002000C);
      gold_word(gs32, gm32, 32, w);
      check_eq("seed_word0", d32, w[31:0]);
      for (int k = 0; k < 3; k++) begin
         step();
         gold_word(gs32, gm32, 32, w);
         check_eq("seed_stream", d32, w[31:0]);
      end

      // Error injection: only the word after the pulse edge has bit 0 flipped.
      ei32 = 1'b1;
      step();
      ei32 = 1'b0;
      gold_word(gs32, gm32, 32, w);
      check_eq("inj_before", d32, w[31:0]);
      step();
      gold_word(gs32, gm32, 32, w);
      check_eq("inj_word", d32, w[31:0] ^ {31'b0, INJ});
      step();
      gold_word(gs32, gm32, 32, w);
      check_eq("inj_after", d32, w[31:0]);

      // Reset overrides a simultaneous seed load and a pending injection.
      rdy32 = 1'b0;
      ei32  = 1'b1;
      step();
      ei32   = 1'b0;
      rst    = 1'b1;
      sl32   = 1'b1;
      seed32 = 31'h5;
      step();
      check_eq("rst_mid_valid", v32, 0);
      check_eq("rst_mid_data", d32, 0);
      rst   = 1'b0;
      sl32  = 1'b0;
      rdy32 = 1'b1;
      step();
      check_eq("rst_mid_valid_up", v32, 1);
      check_eq("rst_mid_word0", d32, first32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
